// File: rtl/fsrc_tx_accum_seq.sv
// fsrc_tx_accum_seq: sequences set/add strobes into the FSRC TX phase
// accumulator for a delayed, fixed-length or open-ended run.
module fsrc_tx_accum_seq #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 stop,
  input  logic [WIDTH-1:0]     init_phase,
  input  logic [WIDTH-1:0]     step,
  input  logic [CNT_WIDTH-1:0] start_delay,
  input  logic [CNT_WIDTH-1:0] run_len,
  input  logic                 acc_overflow,
  output logic                 acc_set,
  output logic [WIDTH-1:0]     acc_set_val,
  output logic                 acc_add,
  output logic [WIDTH-1:0]     acc_add_val,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] ovf_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t               state;
  state_t               nxt;
  logic [CNT_WIDTH-1:0] dly_q;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 add_d;
  logic                 go;
  logic                 abort;
  logic                 fin;
  logic                 cnt_inc;
  logic                 load_in;

  assign go      = (state == IDLE) && start && enable && !stop;
  assign abort   = (state != IDLE) && (stop || !enable);
  assign fin     = (state == RUN) && (len_q != '0)
                   && (cnt == len_q - ONE);
  assign cnt_inc = (state == RUN)
                   || ((state == DELAY) && (nxt == DELAY));
  assign load_in = (state != LOAD) && (nxt == LOAD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (go) nxt = (start_delay != '0) ? DELAY : LOAD;
      DELAY: if (cnt == dly_q - ONE) nxt = LOAD;
      LOAD:  nxt = RUN;
      RUN:   if (fin) nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  always_comb begin
    acc_set = (state == LOAD);
    acc_add = (state == RUN);
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_set_val <= '0;
      acc_add_val <= '0;
      dly_q       <= '0;
      len_q       <= '0;
    end else if (go) begin
      acc_set_val <= init_phase;
      acc_add_val <= step;
      dly_q       <= start_delay;
      len_q       <= run_len;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      add_d <= 1'b0;
      done  <= 1'b0;
    end else begin
      cnt   <= cnt_inc ? cnt + ONE : '0;
      add_d <= (state == RUN);
      done  <= fin && !abort;
    end
  end

  // only overflow caused by our own add last cycle is a new sample
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_count <= '0;
    end else if (load_in) begin
      ovf_count <= '0;
    end else if (add_d && acc_overflow && (ovf_count != '1)) begin
      ovf_count <= ovf_count + ONE;
    end
  end

endmodule

// File: tb/tb_fsrc_tx_accum_seq.sv
// tb_fsrc_tx_accum_seq: directed runs against an accumulator model,
// strobe scoreboard checked on the falling edge.
module tb_fsrc_tx_accum_seq;

  typedef struct {
    bit          is_set;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        start;
  logic        start2;
  logic        stop;
  logic        pre;
  logic [31:0] init_phase;
  logic [31:0] step;
  logic [31:0] start_delay;
  logic [31:0] run_len;

  logic        acc_set, acc_add, busy, done, ovfl;
  logic [31:0] acc_set_val, acc_add_val, ovf_count, acc;

  logic        set2, add2, busy2, done2, ovfl2;
  logic [31:0] sv2, av2, acc2;
  logic [3:0]  ovf2;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  fsrc_tx_accum_seq #(.WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start),
    .stop(stop), .init_phase(init_phase), .step(step),
    .start_delay(start_delay), .run_len(run_len),
    .acc_overflow(ovfl), .acc_set(acc_set), .acc_set_val(acc_set_val),
    .acc_add(acc_add), .acc_add_val(acc_add_val), .busy(busy),
    .done(done), .ovf_count(ovf_count)
  );

  fsrc_tx_accum_seq #(.WIDTH(32), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start2),
    .stop(stop), .init_phase(init_phase), .step(step),
    .start_delay(start_delay[3:0]), .run_len(run_len[3:0]),
    .acc_overflow(ovfl2), .acc_set(set2), .acc_set_val(sv2),
    .acc_add(add2), .acc_add_val(av2), .busy(busy2),
    .done(done2), .ovf_count(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovfl <= 1'b0;
      acc  <= '0;
    end else if (pre) begin
      ovfl <= 1'b1;
    end else if (acc_set) begin
      acc <= acc_set_val;
    end else if (acc_add) begin
      {ovfl, acc} <= {1'b0, acc} + {1'b0, acc_add_val};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovfl2 <= 1'b0;
      acc2  <= '0;
    end else if (set2) begin
      acc2 <= sv2;
    end else if (add2) begin
      {ovfl2, acc2} <= {1'b0, acc2} + {1'b0, av2};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [31:0] ip, input logic [31:0] st,
                          input int n);
    exp_t e;
    e.is_set = 1'b1;
    e.val    = ip;
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      e.is_set = 1'b0;
      e.val    = st;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (acc_set && acc_add) chk("set_add_overlap", 1, 0);
      if (acc_set || acc_add) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {acc_set, acc_add}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", acc_set, e.is_set);
          chk("strobe_val", acc_set ? acc_set_val : acc_add_val, e.val);
        end
      end
    end
  end

  initial begin
    logic [3:0] ex;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    enable = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    stop = 1'b0;
    pre = 1'b0;
    init_phase = '0;
    step = '0;
    start_delay = '0;
    run_len = '0;
    #2;
    chk("rst_flags", {busy, acc_set, acc_add, done}, 0);
    chk("rst_ovf", ovf_count, 0);
    chk("rst_vals", {acc_set_val, acc_add_val}, 0);
    #10 resetn = 1'b1;
    tick();

    // basic run
    step = 32'h4000_0000;
    run_len = 8;
    push_run(32'h0, step, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_set_c1", {busy, acc_set, acc_add}, 3'b110);
    chk("t1_setval", acc_set_val, 0);
    repeat (8) tick();
    chk("t1_add_c9", acc_add, 1);
    tick();
    chk("t1_done_c10", {busy, acc_add, done}, 3'b001);
    tick();
    chk("t1_done_c11", done, 0);
    chk("t1_ovf", ovf_count, 2);

    // start delay
    init_phase = 32'h1234_5678;
    step = 32'h10;
    start_delay = 5;
    run_len = 3;
    push_run(init_phase, step, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      ex = {(c >= 1 && c <= 9), (c == 6), (c >= 7 && c <= 9), (c == 10)};
      chk($sformatf("t2_c%0d", c), {busy, acc_set, acc_add, done}, ex);
      tick();
    end

    // open-ended run, stop after 20 adds
    init_phase = '0;
    step = 32'h8000_0000;
    start_delay = 0;
    run_len = 0;
    push_run(32'h0, step, 20);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("t3_add_c21", acc_add, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_stopped", {busy, acc_add, done}, 0);
    tick();
    chk("t3_ovf", ovf_count, 10);
    chk("t3_nodone", done, 0);
    repeat (3) tick();
    chk("t3_ovf_held", ovf_count, 10);

    // enable drop in DELAY
    start_delay = 10;
    run_len = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_busy", busy, 1);
    repeat (2) tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    chk("t4_abort", {busy, acc_set, done}, 0);
    chk("t4_ovf_kept", ovf_count, 10);
    repeat (12) tick();
    chk("t4_idle", {busy, done}, 0);

    // start and stop together
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("t4_collide", busy, 0);
    tick();
    chk("t4_collide2", busy, 0);

    // start while busy must not touch the latched config
    init_phase = 32'hAAAA_0000;
    step = 32'h5;
    start_delay = 3;
    run_len = 2;
    push_run(init_phase, step, 2);
    start = 1'b1;
    tick();
    init_phase = 32'h0000_FFFF;
    step = 32'h77;
    start_delay = 0;
    run_len = 9;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("t4_set_c4", acc_set, 1);
    chk("t4_setval", acc_set_val, 32'hAAAA_0000);
    tick();
    chk("t4_addval", acc_add_val, 32'h5);
    repeat (2) tick();
    chk("t4_done_c7", done, 1);
    tick();
    chk("t4_ovf", ovf_count, 0);

    // stale overflow held by the accumulator
    pre = 1'b1;
    tick();
    pre = 1'b0;
    init_phase = '0;
    step = 32'h1;
    start_delay = 0;
    run_len = 4;
    push_run(32'h0, step, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_set", acc_set, 1);
    repeat (5) tick();
    chk("t5_done", done, 1);
    tick();
    chk("t5_ovf", ovf_count, 0);

    // saturation on the narrow instance, then async reset mid-run
    step = 32'hFFFF_FFFF;
    run_len = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (30) tick();
    chk("t6_sat", ovf2, 4'hF);
    chk("t6_running", {busy2, add2}, 2'b11);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_flags", {busy2, set2, add2, done2}, 0);
    chk("t6_rst_ovf", ovf2, 0);
    chk("t6_rst_vals", {sv2, av2}, 0);
    chk("t6_rst_main", {busy, ovf_count}, 0);
    #4 resetn = 1'b1;
    tick();
    chk("t6_idle", busy2, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
